// File: rtl/rojobot_cmd_sequencer_pkg.sv
// Shared opcodes, wheel-mask decode and FSM state type for the RojoBot command sequencer.
package rojobot_seq_pkg;

  localparam logic [2:0] OP_STOP    = 3'd0;
  localparam logic [2:0] OP_FWD     = 3'd1;
  localparam logic [2:0] OP_REV     = 3'd2;
  localparam logic [2:0] OP_SPIN_L  = 3'd3;
  localparam logic [2:0] OP_SPIN_R  = 3'd4;
  localparam logic [2:0] OP_PIVOT_L = 3'd5;
  localparam logic [2:0] OP_PIVOT_R = 3'd6;
  localparam logic [2:0] OP_RSVD    = 3'd7;

  localparam int unsigned SIM_TICK_CYCLES = 5;
  localparam int          CMD_W           = 11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_MANUAL
  } seq_state_t;

  // Mask bit order is {left_fwd, left_rev, right_fwd, right_rev}.
  function automatic logic [3:0] op_to_mask(input logic [2:0] op);
    logic [3:0] mask;
    case (op)
      OP_FWD:            mask = 4'b1010;
      OP_REV:            mask = 4'b0101;
      OP_SPIN_L:         mask = 4'b0110;
      OP_SPIN_R:         mask = 4'b1001;
      OP_PIVOT_L:        mask = 4'b0010;
      OP_PIVOT_R:        mask = 4'b1000;
      OP_STOP, OP_RSVD:  mask = 4'b0000;
      default:           mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/rojobot_cmd_sequencer_fifo.sv
// Synchronous command FIFO with registered full/empty flags and a flush that overrides push.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 11
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Push is gated on the registered full flag only: no bypass when a pop coincides.
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
        empty <= 1'b0;
        full  <= (count == CW'(DEPTH - 1));
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
        full  <= 1'b0;
        empty <= (count == CW'(1));
      end
    end
  end

endmodule

// File: rtl/rojobot_cmd_sequencer.sv
// Scripted wheel-motion sequencer: queued {op, len} steps timed in prescaled ticks,
// with a manual pushbutton pass-through and an abort that flushes everything.
//
// state   | meaning
// IDLE    | wheels off, waiting for a queued command
// LOAD    | one cycle: pop head, latch op/len, clear prescaler, wheels off
// RUN     | wheels = mask(op) until step_remaining ticks have elapsed
// MANUAL  | wheels follow interlocked man_btns; FIFO is kept
module rojobot_cmd_sequencer
  import rojobot_seq_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int TICK_CYCLES = 5_000_000,
  parameter bit SIMULATE    = 1'b0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [2:0]                    cmd_op,
  input  logic [7:0]                    cmd_len,
  input  logic                          abort,
  input  logic                          manual_en,
  input  logic [3:0]                    man_btns,
  output logic                          left_fwd,
  output logic                          left_rev,
  output logic                          right_fwd,
  output logic                          right_rev,
  output logic                          busy,
  output logic [2:0]                    cur_op,
  output logic [7:0]                    step_remaining,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int          CW     = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned PERIOD = SIMULATE ? SIM_TICK_CYCLES : TICK_CYCLES;

  seq_state_t       state;
  logic [31:0]      presc;
  logic [3:0]       wheels;
  logic [3:0]       man_safe;
  logic [CMD_W-1:0] head;
  logic [2:0]       head_op;
  logic [7:0]       head_len;
  logic             tick;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;

  assign push      = cmd_valid && !abort;
  assign pop       = (state == ST_LOAD) && !abort && !manual_en;
  assign cmd_ready = !full;
  assign head_op   = head[10:8];
  assign head_len  = head[7:0];
  assign tick      = (presc == PERIOD - 1);

  // A wheel commanded both ways at once is forced fully off.
  assign man_safe = {man_btns[3] & ~man_btns[2], man_btns[2] & ~man_btns[3],
                     man_btns[1] & ~man_btns[0], man_btns[0] & ~man_btns[1]};

  assign {left_fwd, left_rev, right_fwd, right_rev} = wheels;

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (abort),
    .push    (push),
    .wr_data ({cmd_op, cmd_len}),
    .pop     (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      wheels         <= 4'b0000;
      busy           <= 1'b0;
      cur_op         <= 3'd0;
      step_remaining <= 8'd0;
      presc          <= '0;
    end else if (abort) begin
      state          <= (state == ST_MANUAL && manual_en) ? ST_MANUAL : ST_IDLE;
      wheels         <= 4'b0000;
      busy           <= 1'b0;
      cur_op         <= 3'd0;
      step_remaining <= 8'd0;
      presc          <= '0;
    end else if (manual_en) begin
      // The entry cycle drives zeros so motion never jumps straight to the buttons.
      state          <= ST_MANUAL;
      wheels         <= (state == ST_MANUAL) ? man_safe : 4'b0000;
      busy           <= 1'b0;
      cur_op         <= 3'd0;
      step_remaining <= 8'd0;
      presc          <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          wheels <= 4'b0000;
          presc  <= '0;
          if (!empty) begin
            state <= ST_LOAD;
            busy  <= 1'b1;
          end
        end
        ST_LOAD: begin
          presc <= '0;
          if (head_len != 8'd0) begin
            state          <= ST_RUN;
            busy           <= 1'b1;
            wheels         <= op_to_mask(head_op);
            cur_op         <= head_op;
            step_remaining <= head_len;
          end else if (fifo_count > CW'(1)) begin
            state <= ST_LOAD;
            busy  <= 1'b1;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (tick) begin
            presc          <= '0;
            step_remaining <= step_remaining - 8'd1;
            if (step_remaining == 8'd1) begin
              wheels <= 4'b0000;
              cur_op <= 3'd0;
              state  <= empty ? ST_IDLE : ST_LOAD;
              busy   <= !empty;
            end
          end else begin
            presc <= presc + 32'd1;
          end
        end
        ST_MANUAL: begin
          state  <= ST_IDLE;
          wheels <= 4'b0000;
          busy   <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          wheels <= 4'b0000;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rojobot_cmd_sequencer.sv
// Scoreboard bench: each accepted non-empty command queues its expected step; a monitor
// pops and checks every step window (mask, op, length, steadiness) as the DUT runs it.
module tb_rojobot_cmd_sequencer;

  localparam int P = 5;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_len;
  logic       abort;
  logic       manual_en;
  logic [3:0] man_btns;
  logic       left_fwd, left_rev, right_fwd, right_rev;
  logic       busy;
  logic [2:0] cur_op;
  logic [7:0] step_remaining;
  logic [2:0] fifo_count;

  typedef struct {
    int op;
    int mask;
    int len;
    int cycles;
  } exp_t;

  exp_t sb[$];
  int   win_start[$];
  int   win_end[$];
  int   n_cmp = 0;
  int   n_mis = 0;
  int   cyc = 0;
  int   push_cyc = 0;
  int   conflicts = 0;
  int   stray = 0;
  bit   cut = 0;
  bit   in_manual = 0;
  bit   active = 0;

  rojobot_cmd_sequencer #(
    .FIFO_DEPTH  (4),
    .TICK_CYCLES (5_000_000),
    .SIMULATE    (1'b1)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),
    .cmd_len        (cmd_len),
    .abort          (abort),
    .manual_en      (manual_en),
    .man_btns       (man_btns),
    .left_fwd       (left_fwd),
    .left_rev       (left_rev),
    .right_fwd      (right_fwd),
    .right_rev      (right_rev),
    .busy           (busy),
    .cur_op         (cur_op),
    .step_remaining (step_remaining),
    .fifo_count     (fifo_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int tb_mask(input int op);
    case (op)
      1: return 4'b1010;
      2: return 4'b0101;
      3: return 4'b0110;
      4: return 4'b1001;
      5: return 4'b0010;
      6: return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Call at a negedge; returns at the negedge right after the sampling edge.
  task automatic push_cmd(input int op, input int len, input bit exp_ready);
    exp_t e;
    cmd_valid = 1'b1;
    cmd_op    = 3'(op);
    cmd_len   = 8'(len);
    check("cmd_ready", cmd_ready, exp_ready);
    if (exp_ready && len != 0) begin
      e = '{op: op, mask: tb_mask(op), len: len, cycles: len * P};
      sb.push_back(e);
    end
    @(negedge clk);
    push_cyc  = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_run(input int max);
    int n = 0;
    while (step_remaining == 0 && n < max) begin
      @(negedge clk);
      n++;
    end
    check("wait_run_timeout", int'(step_remaining != 0), 1);
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (!(busy == 1'b0 && fifo_count == 0 && step_remaining == 0) && n < max) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle_timeout", int'(busy == 1'b0 && fifo_count == 0 && step_remaining == 0), 1);
  endtask

  // Step-window monitor: a window is the run of cycles with step_remaining != 0.
  initial begin
    exp_t cur;
    logic [3:0] w, prev_w;
    int cnt, bad, last_nz;
    prev_w = 4'b0000;
    cnt = 0; bad = 0; last_nz = 0;
    cur = '{op: -1, mask: -1, len: -1, cycles: -1};
    forever begin
      @(negedge clk);
      w = {left_fwd, left_rev, right_fwd, right_rev};
      if (!reset) begin
        if ((w[3] && w[2]) || (w[1] && w[0]) ||
            (prev_w[3] && w[2]) || (prev_w[2] && w[3]) ||
            (prev_w[1] && w[0]) || (prev_w[0] && w[1]))
          conflicts++;
        if (step_remaining != 0) begin
          if (!active) begin
            active = 1;
            cnt = 1;
            bad = 0;
            win_start.push_back(cyc);
            check("sb_has_entry", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
              cur = sb.pop_front();
              check("step_mask", w, cur.mask);
              check("step_op", cur_op, cur.op);
              check("step_len", step_remaining, cur.len);
            end else begin
              cur = '{op: -1, mask: -1, len: -1, cycles: -1};
            end
          end else begin
            cnt++;
            if (int'(w) != cur.mask) bad++;
          end
          last_nz = cyc;
        end else begin
          if (active) begin
            active = 0;
            win_end.push_back(last_nz);
            if (!cut) begin
              check("step_cycles", cnt, cur.cycles);
              check("step_steady", bad, 0);
            end
            cut = 0;
          end
          if (w != 4'b0000 && !in_manual) stray++;
        end
      end
      prev_w = w;
    end
  end

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_len = 8'd0;
    abort = 1'b0; manual_en = 1'b0; man_btns = 4'b0000;
    repeat (3) @(negedge clk);
    check("rst_wheels", {left_fwd, left_rev, right_fwd, right_rev}, 0);
    check("rst_busy", busy, 0);
    check("rst_cur_op", cur_op, 0);
    check("rst_remaining", step_remaining, 0);
    check("rst_count", fifo_count, 0);
    check("rst_ready", cmd_ready, 1);
    reset = 1'b0;
    @(negedge clk);

    // FWD len 3: wheels rise two edges after the push edge, 15 cycles long.
    win_start.delete(); win_end.delete();
    push_cmd(1, 3, 1);
    wait_idle(100);
    check("t1_windows", win_start.size(), 1);
    if (win_start.size() == 1) check("t1_latency", win_start[0] - push_cyc, 2);
    check("t1_busy_low", busy, 0);

    // FWD 2 then REV 2: exactly one all-off cycle between the windows.
    win_start.delete(); win_end.delete();
    push_cmd(1, 2, 1);
    push_cmd(2, 2, 1);
    wait_idle(100);
    check("t2_windows", win_start.size(), 2);
    if (win_start.size() == 2 && win_end.size() == 2)
      check("t2_gap", win_start[1] - win_end[0], 2);

    // Fill the FIFO while step 1 runs; the fifth push is refused.
    push_cmd(1, 4, 1);
    wait_run(10);
    push_cmd(4, 1, 1);
    push_cmd(6, 1, 1);
    push_cmd(5, 1, 1);
    push_cmd(0, 1, 1);
    check("t3_count_full", fifo_count, 4);
    push_cmd(2, 1, 0);
    check("t3_count_after_refuse", fifo_count, 4);
    wait_idle(200);

    // Abort mid-step with 3 queued plus a same-cycle push.
    push_cmd(1, 4, 1);
    push_cmd(2, 1, 1);
    push_cmd(3, 1, 1);
    push_cmd(4, 1, 1);
    wait_run(10);
    check("t4_count_before", fifo_count, 3);
    abort = 1'b1; cmd_valid = 1'b1; cmd_op = 3'd4; cmd_len = 8'd1;
    check("t4_ready_at_abort", cmd_ready, 1);
    cut = 1;
    sb.delete();
    @(negedge clk);
    abort = 1'b0; cmd_valid = 1'b0;
    check("t4_wheels", {left_fwd, left_rev, right_fwd, right_rev}, 0);
    check("t4_count", fifo_count, 0);
    check("t4_busy", busy, 0);
    check("t4_remaining", step_remaining, 0);
    repeat (40) @(negedge clk);
    check("t4_still_idle", busy, 0);

    // Manual override mid-step; queued steps resume after release.
    push_cmd(1, 4, 1);
    push_cmd(2, 1, 1);
    push_cmd(3, 1, 1);
    wait_run(10);
    manual_en = 1'b1; man_btns = 4'b1100; in_manual = 1; cut = 1;
    @(negedge clk);
    check("t5_enter_zero", {left_fwd, left_rev, right_fwd, right_rev}, 0);
    check("t5_count_kept", fifo_count, 2);
    check("t5_busy", busy, 0);
    @(negedge clk);
    check("t5_interlock_left", {left_fwd, left_rev, right_fwd, right_rev}, 4'b0000);
    man_btns = 4'b1000;
    @(negedge clk);
    check("t5_left_fwd", {left_fwd, left_rev, right_fwd, right_rev}, 4'b1000);
    man_btns = 4'b0011;
    @(negedge clk);
    check("t5_interlock_right", {left_fwd, left_rev, right_fwd, right_rev}, 4'b0000);
    man_btns = 4'b1010;
    @(negedge clk);
    check("t5_both_fwd", {left_fwd, left_rev, right_fwd, right_rev}, 4'b1010);
    manual_en = 1'b0;
    @(negedge clk);
    check("t5_exit_zero", {left_fwd, left_rev, right_fwd, right_rev}, 0);
    in_manual = 0;
    man_btns = 4'b0000;
    wait_idle(200);

    // Reserved op runs as STOP for 10 cycles; len 0 is popped without motion.
    win_start.delete(); win_end.delete();
    push_cmd(7, 2, 1);
    push_cmd(1, 0, 1);
    wait_idle(100);
    check("t6_windows", win_start.size(), 1);
    check("t6_count", fifo_count, 0);
    repeat (10) @(negedge clk);

    check("final_sb_empty", sb.size(), 0);
    check("final_no_conflict", conflicts, 0);
    check("final_no_stray", stray, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
